randomizer_core: RTL and testbench

RANDOMIZER_CORE -- requirements
Module: randomizer

---
 rtl/randomizer_core.sv | 101 ++++++++++
 tb/tb_randomizer_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/randomizer_core.sv
// randomizer_core: multi-channel maximal-length Fibonacci LFSR generator.
// Ports: clk clock; rndm_init seeds channel rndm_ch (sync, active-high);
//        rndm_ready steps channel rndm_ch; rndm_seed seed value;
//        rndm_out registered value (unsigned or symmetric signed).
module randomizer_core #(
   parameter int NR_CHANNELS  = 1,
   parameter int OUTPUT_WIDTH = 16,
   parameter int SIGNED       = 0,
   localparam int CW = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rndm_init,
   input  logic [CW-1:0]           rndm_ch,
   input  logic [OUTPUT_WIDTH-1:0] rndm_seed,
   input  logic                    rndm_ready,
   output logic [OUTPUT_WIDTH-1:0] rndm_out
);

   localparam int W = OUTPUT_WIDTH;

   function automatic logic [31:0] tap(input int n);
      return 32'd1 << (n - 1);
   endfunction

   // Maximal-length XOR tap sets, 1-based tap positions.
   function automatic logic [31:0] tap_mask(input int w);
      logic [31:0] m;
      m = '0;
      case (w)
         3:  m = tap(3)  | tap(2);
         4:  m = tap(4)  | tap(3);
         5:  m = tap(5)  | tap(3);
         6:  m = tap(6)  | tap(5);
         7:  m = tap(7)  | tap(6);
         8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
         9:  m = tap(9)  | tap(5);
         10: m = tap(10) | tap(7);
         11: m = tap(11) | tap(9);
         12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
         13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
         14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
         15: m = tap(15) | tap(14);
         16: m = tap(16) | tap(15) | tap(13) | tap(4);
         17: m = tap(17) | tap(14);
         18: m = tap(18) | tap(11);
         19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
         20: m = tap(20) | tap(17);
         21: m = tap(21) | tap(19);
         22: m = tap(22) | tap(21);
         23: m = tap(23) | tap(18);
         24: m = tap(24) | tap(23) | tap(22) | tap(17);
         25: m = tap(25) | tap(22);
         26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
         27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
         28: m = tap(28) | tap(25);
         29: m = tap(29) | tap(27);
         30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
         31: m = tap(31) | tap(28);
         32: m = tap(32) | tap(22) | tap(2)  | tap(1);
         default: m = '0;
      endcase
      return m;
   endfunction

   localparam logic [W-1:0] TAPS = W'(tap_mask(W));
   localparam logic [W-1:0] ONE  = W'(1);
   // Inverting the MSB turns 1..2^W-1 into a symmetric signed range.
   localparam logic [W-1:0] FLIP =
      (SIGNED != 0) ? {1'b1, {(W-1){1'b0}}} : '0;

   logic [W-1:0] state [NR_CHANNELS] = '{default: ONE};
   logic [W-1:0] out_q = ONE ^ FLIP;

   logic         ch_ok;
   logic [W-1:0] cur;
   logic [W-1:0] nxt;
   logic [W-1:0] seed_s;

   always_comb begin
      ch_ok  = 32'(rndm_ch) < NR_CHANNELS;
      cur    = ch_ok ? state[rndm_ch] : ONE;
      nxt    = {cur[W-2:0], ^(cur & TAPS)};
      // A zero seed would lock the LFSR, so it is replaced by 1.
      seed_s = (rndm_seed != '0) ? rndm_seed : ONE;
   end

   always_ff @(posedge clk) begin
      if (ch_ok) begin
         if (rndm_init) begin
            state[rndm_ch] <= seed_s;
            out_q          <= seed_s ^ FLIP;
         end else if (rndm_ready) begin
            state[rndm_ch] <= nxt;
            out_q          <= nxt ^ FLIP;
         end
      end
   end

   assign rndm_out = out_q;

endmodule

// File: tb/tb_randomizer_core.sv
// tb_randomizer_core: directed vectors and sequences for randomizer_core.
// Ports: none (drives four differently parameterised instances).
module tb_randomizer_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // a: W=8 unsigned, 3 ch; b: W=8 signed, 1 ch
   // c: W=24 unsigned, 3 ch; d: W=16 unsigned, 1 ch
   logic        init_a = 0, ready_a = 0;
   logic [1:0]  ch_a = 0;
   logic [7:0]  seed_a = 0;
   logic [7:0]  out_a;
   logic        init_b = 0, ready_b = 0;
   logic [0:0]  ch_b = 0;
   logic [7:0]  seed_b = 0;
   logic [7:0]  out_b;
   logic        init_c = 0, ready_c = 0;
   logic [1:0]  ch_c = 0;
   logic [23:0] seed_c = 0;
   logic [23:0] out_c;
   logic        init_d = 0, ready_d = 0;
   logic [0:0]  ch_d = 0;
   logic [15:0] seed_d = 0;
   logic [15:0] out_d;

   randomizer_core #(.NR_CHANNELS(3), .OUTPUT_WIDTH(8), .SIGNED(0)) u_a (
      .clk(clk), .rndm_init(init_a), .rndm_ch(ch_a),
      .rndm_seed(seed_a), .rndm_ready(ready_a), .rndm_out(out_a));
   randomizer_core #(.NR_CHANNELS(1), .OUTPUT_WIDTH(8), .SIGNED(1)) u_b (
      .clk(clk), .rndm_init(init_b), .rndm_ch(ch_b),
      .rndm_seed(seed_b), .rndm_ready(ready_b), .rndm_out(out_b));
   randomizer_core #(.NR_CHANNELS(3), .OUTPUT_WIDTH(24), .SIGNED(0)) u_c (
      .clk(clk), .rndm_init(init_c), .rndm_ch(ch_c),
      .rndm_seed(seed_c), .rndm_ready(ready_c), .rndm_out(out_c));
   randomizer_core #(.NR_CHANNELS(1), .OUTPUT_WIDTH(16), .SIGNED(0)) u_d (
      .clk(clk), .rndm_init(init_d), .rndm_ch(ch_d),
      .rndm_seed(seed_d), .rndm_ready(ready_d), .rndm_out(out_d));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] lfsr8(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [15:0] lfsr16(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
   endfunction

   function automatic logic [23:0] lfsr24(input logic [23:0] s);
      return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
   endfunction

   typedef struct {
      logic       init;
      logic       ready;
      logic [1:0] ch;
      logic [7:0] seed;
      logic [7:0] exp;
   } vec_t;

   vec_t vt [17];

   initial begin
      logic [7:0]  ma;
      logic [23:0] mc [3];
      logic [15:0] md;
      bit          seen_a [256];
      bit          seen_b [256];
      int          zero_a, neg_b, cnt_a, cnt_b;

      vt[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h01};
      vt[1]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h02};
      vt[2]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h04};
      vt[3]  = '{1'b1, 1'b1, 2'd1, 8'h80, 8'h80};
      vt[4]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h01};
      vt[5]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h08};
      vt[6]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h11};
      vt[7]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h11};
      vt[8]  = '{1'b1, 1'b0, 2'd3, 8'h55, 8'h11};
      vt[9]  = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h11};
      vt[10] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h02};
      vt[11] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h02};
      vt[12] = '{1'b1, 1'b0, 2'd0, 8'hA5, 8'hA5};
      vt[13] = '{1'b1, 1'b0, 2'd0, 8'h3C, 8'h3C};
      vt[14] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h79};
      vt[15] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h04};
      vt[16] = '{1'b0, 1'b1, 2'd0, 8'h00, 8'hF3};

      // Power-up values before any clock edge
      #1;
      chk("pwrup_a", 32'(out_a), 32'h01);
      chk("pwrup_b", 32'(out_b), 32'h81);
      chk("pwrup_c", 32'(out_c), 32'h1);
      chk("pwrup_d", 32'(out_d), 32'h1);

      // Directed table on the 3-channel 8-bit instance
      for (int i = 0; i < 17; i++) begin
         init_a  = vt[i].init;
         ready_a = vt[i].ready;
         ch_a    = vt[i].ch;
         seed_a  = vt[i].seed;
         tick();
         chk($sformatf("vec%0d", i), 32'(out_a), 32'(vt[i].exp));
      end
      init_a = 0; ready_a = 0;

      // Full period, unsigned and signed, seed 0
      init_a = 1; ch_a = 0; seed_a = 0;
      init_b = 1; seed_b = 0;
      tick();
      chk("a_seed0", 32'(out_a), 32'h01);
      chk("b_seed0", 32'(out_b), 32'h81);
      init_a = 0; ready_a = 1;
      init_b = 0; ready_b = 1;
      ma = 8'h01;
      zero_a = 0; neg_b = 0;
      for (int i = 0; i < 256; i++) begin
         seen_a[i] = 0;
         seen_b[i] = 0;
      end
      for (int i = 0; i < 255; i++) begin
         tick();
         ma = lfsr8(ma);
         chk($sformatf("a_step%0d", i), 32'(out_a), 32'(ma));
         chk($sformatf("b_step%0d", i), 32'(out_b), 32'(ma ^ 8'h80));
         if (out_a == 8'h00) zero_a++;
         if (out_b == 8'h80) neg_b++;
         seen_a[out_a] = 1;
         seen_b[out_b] = 1;
      end
      ready_a = 0; ready_b = 0;
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 256; i++) begin
         if (seen_a[i]) cnt_a++;
         if (seen_b[i]) cnt_b++;
      end
      chk("a_zero_hits", 32'(zero_a), 32'd0);
      chk("b_minneg_hits", 32'(neg_b), 32'd0);
      chk("a_codes", 32'(cnt_a), 32'd255);
      chk("b_codes", 32'(cnt_b), 32'd255);
      chk("a_wrap", 32'(out_a), 32'h01);

      // Three interleaved 24-bit channels
      mc[0] = 24'h040000; mc[1] = 24'h000400; mc[2] = 24'h000004;
      init_c = 1;
      for (int k = 0; k < 3; k++) begin
         ch_c = 2'(k);
         seed_c = mc[k];
         tick();
         chk($sformatf("c_seed%0d", k), 32'(out_c), 32'(mc[k]));
      end
      init_c = 0; ready_c = 1;
      for (int i = 0; i < 60; i++) begin
         ch_c = 2'(i % 3);
         tick();
         mc[i % 3] = lfsr24(mc[i % 3]);
         chk($sformatf("c_step%0d", i), 32'(out_c), 32'(mc[i % 3]));
         if (out_c == 24'h0) chk("c_nonzero", 32'(out_c), 32'h1);
      end
      ch_c = 2'd3;
      tick();
      chk("c_ch3_ready", 32'(out_c), 32'(mc[2]));
      init_c = 1; seed_c = 24'h123456;
      tick();
      chk("c_ch3_init", 32'(out_c), 32'(mc[2]));
      init_c = 0; ch_c = 2'd0;
      tick();
      mc[0] = lfsr24(mc[0]);
      chk("c_ch0_after", 32'(out_c), 32'(mc[0]));
      ready_c = 0;

      // 16-bit run with a 50-cycle pause
      init_d = 1; seed_d = 16'hFFFF;
      tick();
      chk("d_seed", 32'(out_d), 32'hFFFF);
      init_d = 0; ready_d = 1;
      md = 16'hFFFF;
      for (int i = 0; i < 20; i++) begin
         tick();
         md = lfsr16(md);
         chk($sformatf("d_run%0d", i), 32'(out_d), 32'(md));
      end
      ready_d = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         chk($sformatf("d_hold%0d", i), 32'(out_d), 32'(md));
      end
      ready_d = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         md = lfsr16(md);
         chk($sformatf("d_resume%0d", i), 32'(out_d), 32'(md));
      end
      // Reload mid-run restarts from the seed
      init_d = 1; seed_d = 16'hFFFF;
      tick();
      chk("d_reseed", 32'(out_d), 32'hFFFF);
      init_d = 0;
      tick();
      chk("d_reseed_step", 32'(out_d), 32'(lfsr16(16'hFFFF)));
      ready_d = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
